// File: rtl/cozy_uart_tx_pkg.sv
// Shared definitions for the cozy UART transmitter: register offsets,
// STATUS bit positions, default base address and transmit FSM states.
package cozy_uart_tx_pkg;

    // Register offsets within the two-word window (selected by bus_addr[0])
    localparam logic UART_DATA   = 1'b0;
    localparam logic UART_STATUS = 1'b1;

    // STATUS bit positions
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_BUSY   = 2;
    localparam int ST_OVF    = 3;
    localparam int ST_IRQ_EN = 4;

    // Default word address of DATA (must be even; STATUS is the next word)
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF00;

    // Transmit sequencer states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Pack the STATUS read word: count in the high byte, flags in the low bits
    function automatic logic [15:0] status_word(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic       irq_en,
        input logic [7:0] count
    );
        return {count, 3'b000, irq_en, ovf, busy, empty, full};
    endfunction

endpackage

// File: rtl/cozy_sync_fifo.sv
// Synchronous circular-buffer FIFO with show-ahead read data.
// A push while full is accepted only when a pop happens in the same cycle.
module cozy_sync_fifo
    import cozy_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    count
);

    localparam int            DEPTH    = 2 ** LOG2;
    localparam logic [LOG2-1:0] PTR_ONE  = LOG2'(1'b1);
    localparam logic [LOG2:0]   CNT_ONE  = (LOG2 + 1)'(1'b1);
    localparam logic [LOG2:0]   CNT_FULL = {1'b1, {LOG2{1'b0}}};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LOG2-1:0]  r_wr_ptr;
    logic [LOG2-1:0]  r_rd_ptr;
    logic [LOG2:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    // Storage array: data only, no reset needed since count gates visibility
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy count; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cozy_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the cozy_cpu data bus.
// DATA writes are queued in a FIFO; STATUS reads return with the same
// one-cycle latency as cozy_memory so the top-level read mux is uniform.
module cozy_uart_tx
    import cozy_uart_tx_pkg::*;
#(
    parameter int          CLK_DIV   = 434,
    parameter int          FIFO_LOG2 = 4,
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] bus_addr,
    input  logic [1:0]  bus_bwe,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    output logic        bus_sel,
    output logic        txd,
    output logic        irq
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    // Bus-side registers
    logic [15:0] r_bus_dout;
    logic        r_bus_sel;
    logic        r_ovf;
    logic        r_irq_en;
    logic        r_irq;

    // Transmit sequencer registers
    tx_state_e   r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_sh;
    logic        r_txd;

    // Sequencer next-state values
    tx_state_e   w_state_nxt;
    logic [15:0] w_baud_nxt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  w_sh_nxt;
    logic        w_txd_nxt;
    logic        w_pop;

    // Decode, FIFO and status wires
    logic               w_hit;
    logic               w_wr_data;
    logic               w_wr_status;
    logic               w_push;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [FIFO_LOG2:0] w_count;
    logic [7:0]         w_fifo_dout;
    logic               w_busy;
    logic               w_baud_zero;
    logic [15:0]        w_status;
    logic [15:0]        w_rd_data;
    logic               w_unused;

    assign w_hit       = (bus_addr[15:1] == BASE_ADDR[15:1]);
    assign w_wr_data   = w_hit & (bus_addr[0] == UART_DATA) & bus_bwe[0];
    assign w_wr_status = w_hit & (bus_addr[0] == UART_STATUS) & bus_bwe[0];
    assign w_push      = w_wr_data & (~w_full | w_pop);
    assign w_drop      = w_wr_data & w_full & ~w_pop;
    assign w_busy      = (r_state != TX_IDLE);
    assign w_baud_zero = (r_baud == 16'd0);
    assign w_status    = status_word(w_full, w_empty, w_busy, r_ovf, r_irq_en, 8'(w_count));
    assign w_unused    = ^{bus_bwe[1], bus_din[15:8]};

    assign bus_dout = r_bus_dout;
    assign bus_sel  = r_bus_sel;
    assign txd      = r_txd;
    assign irq      = r_irq;

    cozy_sync_fifo #(
        .WIDTH (8),
        .LOG2  (FIFO_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (bus_din[7:0]),
        .dout    (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    // Read mux: only STATUS returns a non-zero word; misses and DATA read 0
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_hit && (bus_addr[0] == UART_STATUS)) begin
            w_rd_data = w_status;
        end else begin
            w_rd_data = 16'h0000;
        end
    end

    // Bus read pipeline, sticky overflow, interrupt enable and registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_dout <= 16'h0000;
            r_bus_sel  <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq_en   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_bus_dout <= w_rd_data;
            r_bus_sel  <= w_hit;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && bus_din[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_status) begin
                r_irq_en <= bus_din[ST_IRQ_EN];
            end
            r_irq <= r_irq_en & w_empty & ~w_busy;
        end
    end

    // Sequencer next-state: each bit holds for CLK_DIV cycles; stop bit chains
    // straight into the next start bit when more data is queued
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit_idx;
        w_sh_nxt    = r_sh;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_fifo_dout;
                    w_txd_nxt   = 1'b0;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_state_nxt = TX_START;
                end else begin
                    w_txd_nxt   = 1'b1;
                    w_state_nxt = TX_IDLE;
                end
            end
            TX_START: begin
                if (w_baud_zero) begin
                    w_txd_nxt   = r_sh[0];
                    w_bit_nxt   = 3'd0;
                    w_baud_nxt  = BAUD_RELOAD;
                    w_state_nxt = TX_DATA;
                end else begin
                    w_baud_nxt  = r_baud - 16'd1;
                end
            end
            TX_DATA: begin
                if (w_baud_zero) begin
                    w_baud_nxt = BAUD_RELOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = TX_STOP;
                    end else begin
                        w_sh_nxt  = {1'b0, r_sh[7:1]};
                        w_txd_nxt = r_sh[1];
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            TX_STOP: begin
                if (w_baud_zero) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_sh_nxt    = w_fifo_dout;
                        w_txd_nxt   = 1'b0;
                        w_baud_nxt  = BAUD_RELOAD;
                        w_state_nxt = TX_START;
                    end else begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = TX_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud - 16'd1;
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_state_nxt = TX_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset forces the line high immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= TX_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_sh      <= 8'h00;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_sh      <= w_sh_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

endmodule
